// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the single-cycle MIPS datapath:
//   - opcode constants used by the fetch stage and the main control decoder
//   - the run-control FSM state type of the fetch stage
//   - HALT_WORD, the instruction word that stops execution
//   - branch_offset(): sign-extended, word-scaled branch displacement
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [31:0] HALT_WORD = {OP_HALT, 26'h000_0000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // Branch displacement is a signed word count; turn it into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock/reset signal of the fetch stage.
//   master : host/control side - drives run control (start, stall),
//            control-unit outputs (branch, jump, Zero) and the program-load
//            port (imem_we, imem_waddr, imem_wdata); observes fetch results.
//   slave  : the fetch stage itself - drives instr and its decoded fields,
//            pc, pc_plus4, instr_valid and halted.
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
  parameter int IMEM_DEPTH = 64
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          start;
  logic          stall;
  logic          branch;
  logic          jump;
  logic          Zero;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  logic [31:0]   instr;
  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    func;
  logic [15:0]   imm16;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          instr_valid;
  logic          halted;

  modport master (
    output start, stall, branch, jump, Zero, imem_we, imem_waddr, imem_wdata,
    input  instr, opcode, rs, rt, rd, func, imm16, pc, pc_plus4,
           instr_valid, halted
  );

  modport slave (
    input  start, stall, branch, jump, Zero, imem_we, imem_waddr, imem_wdata,
    output instr, opcode, rs, rt, rd, func, imm16, pc, pc_plus4,
           instr_valid, halted
  );

endinterface

// File: rtl/next_pc.sv
// -----------------------------------------------------------------------------
// next_pc
// Combinational next-PC resolution for the fetch stage.
// Ports:
//   pc_plus4 in 32 : sequential successor of the current PC
//   instr    in 32 : currently fetched instruction (jump index, branch imm)
//   branch   in 1  : main control says "branch instruction"
//   jump     in 1  : main control says "jump instruction"
//   Zero     in 1  : ALU comparison result
//   next_pc  out 32: PC to load at the next active edge
// Priority: jump, then taken branch, then fall-through.
// -----------------------------------------------------------------------------
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        jump,
  input  logic        Zero,
  output logic [31:0] next_pc
);

  // The opcode bits play no part in the target computation.
  logic unused_opcode;
  assign unused_opcode = ^instr[31:26];

  // Select the redirect target; arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch && Zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage of the single-cycle MIPS datapath: program counter, instruction
// memory with a program-load write port, field split of the fetched word and
// an IDLE/RUN/HALT run-control FSM.
// Ports:
//   clk   in 1 : rising-edge clock
//   rst_n in 1 : synchronous active-low reset (returns to IDLE, pc = 0;
//                memory contents are kept)
//   bus   slave modport of instr_fetch_if (run control, control-unit inputs,
//         program-load port, fetched instruction/fields, pc, status)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] HALT_WORD  = 32'hFC00_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.slave   bus
);
  import mips_pkg::*;

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         halted_r;
  logic [31:0]  mem_r [IMEM_DEPTH];

  logic         running_s;
  logic         out_of_range_s;
  logic         is_halt_s;
  logic [31:0]  instr_s;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  next_pc_s;

  assign running_s      = (state_r == ST_RUN);
  assign pc_plus4_s     = pc_r + 32'd4;
  // Any PC bit above the word-index field means we ran off the memory.
  assign out_of_range_s = (pc_r[31:AW+2] != {(30-AW){1'b0}});
  assign is_halt_s      = (instr_s == HALT_WORD);

  // Combinational fetch; the memory is only visible while running in range.
  always_comb begin
    instr_s = 32'd0;
    if (running_s && !out_of_range_s) begin
      instr_s = mem_r[pc_r[AW+1:2]];
    end else begin
      instr_s = 32'd0;
    end
  end

  next_pc u_next_pc (
    .pc_plus4 (pc_plus4_s),
    .instr    (instr_s),
    .branch   (bus.branch),
    .jump     (bus.jump),
    .Zero     (bus.Zero),
    .next_pc  (next_pc_s)
  );

  // Program-load port: writes are only taken while not executing.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (state_r != ST_RUN)) begin
      mem_r[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // Run-control FSM and program counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= 32'd0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A stall freezes everything, including halt detection.
          if (!bus.stall) begin
            if (is_halt_s || out_of_range_s) begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= next_pc_s;
            end
          end
        end
        ST_HALT: begin
          if (bus.start) begin
            state_r  <= ST_RUN;
            pc_r     <= 32'd0;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          pc_r     <= 32'd0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr       = instr_s;
  assign bus.opcode      = instr_s[31:26];
  assign bus.rs          = instr_s[25:21];
  assign bus.rt          = instr_s[20:16];
  assign bus.rd          = instr_s[15:11];
  assign bus.func        = instr_s[5:0];
  assign bus.imm16       = instr_s[15:0];
  assign bus.pc          = pc_r;
  assign bus.pc_plus4    = pc_plus4_s;
  assign bus.instr_valid = running_s && !bus.stall && !out_of_range_s && !is_halt_s;
  assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. Each cycle the stimulus process drives
// inputs and pushes the expected outputs (from an abstract program-execution
// model) into a queue; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.IMEM_DEPTH(64)) bus ();

  instr_fetch #(.IMEM_DEPTH(64), .HALT_WORD(32'hFC00_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int valid_seen = 0;

  // Abstract machine: 0 = idle, 1 = running, 2 = halted.
  int          m_state = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_mem [64];

  localparam logic [31:0] W_ADD = {OP_RTYPE, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] W_SUB = {OP_RTYPE, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22};
  localparam logic [31:0] W_LW  = {OP_LW, 5'd1, 5'd4, 16'h0008};
  localparam logic [31:0] W_BEQ = {OP_BEQ, 5'd1, 5'd2, 16'hFFFE};
  localparam logic [31:0] W_J   = {OP_J, 26'h000_0005};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
      chk("instr", bus.instr, e.instr);
      chk("fields", {5'd0, bus.opcode, bus.rs, bus.rt, bus.rd, bus.func},
          {5'd0, e.instr[31:11], e.instr[5:0]});
      chk("imm16", {16'd0, bus.imm16}, {16'd0, e.instr[15:0]});
      chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, e.valid});
      chk("halted", {31'd0, bus.halted}, {31'd0, e.halted});
      if (bus.instr_valid === 1'b1) valid_seen++;
    end
  end

  // One clock of stimulus plus the model's view of that cycle.
  task automatic cycle(input bit r, input bit st, input bit sl, input bit br,
                       input bit j, input bit z, input bit we, input int wa,
                       input logic [31:0] wd);
    exp_t        e;
    bit          running;
    bit          oor;
    logic [31:0] ins;
    logic [31:0] p4;
    logic [31:0] nxt;
    int          off;
    @(posedge clk);
    #1;
    rst_n = r;
    bus.start = st;
    bus.stall = sl;
    bus.branch = br;
    bus.jump = j;
    bus.Zero = z;
    bus.imem_we = we;
    bus.imem_waddr = 6'(wa);
    bus.imem_wdata = wd;

    running = (m_state == 1);
    oor = (m_pc >= 32'd256);
    ins = (running && !oor) ? m_mem[m_pc / 32'd4] : 32'd0;
    e.pc = m_pc;
    e.instr = ins;
    e.valid = running && !sl && !oor && (ins != HALT_WORD);
    e.halted = (m_state == 2);
    exp_q.push_back(e);

    if (we && m_state != 1) m_mem[wa] = wd;
    p4 = m_pc + 32'd4;
    if (j) begin
      nxt = {p4[31:28], ins[25:0], 2'b00};
    end else if (br && z) begin
      off = $signed(ins[15:0]);
      nxt = p4 + 32'(off * 4);
    end else begin
      nxt = p4;
    end
    if (!r) begin
      m_state = 0;
      m_pc = 32'd0;
    end else begin
      case (m_state)
        0: if (st) m_state = 1;
        1: if (!sl) begin
             if (oor || ins == HALT_WORD) m_state = 2;
             else m_pc = nxt;
           end
        2: if (st) begin
             m_state = 1;
             m_pc = 32'd0;
           end
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic do_start();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
  endtask

  task automatic load(input int a, input logic [31:0] w);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, a, w);
  endtask

  function automatic logic [31:0] rand_word();
    int v;
    case ($urandom % 16)
      0: return HALT_WORD;
      1, 2: return {OP_J, 20'h0_0000, 6'($urandom)};
      3, 4, 5: begin
        v = $urandom_range(0, 16) - 8;
        return {OP_BEQ, 10'($urandom), 16'(v)};
      end
      6: return $urandom;
      default: return {OP_LW, 26'($urandom)};
    endcase
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.branch = 1'b0;
    bus.jump = 1'b0;
    bus.Zero = 1'b0;
    bus.imem_we = 1'b0;
    bus.imem_waddr = 6'd0;
    bus.imem_wdata = 32'd0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state, then clear the whole memory.
    do_reset();
    for (int i = 0; i < 64; i++) load(i, 32'd0);

    // Straight-line program ending in HALT_WORD.
    load(0, W_ADD);
    load(1, W_SUB);
    load(2, W_LW);
    load(3, HALT_WORD);
    valid_seen = 0;
    do_start();
    repeat (6) idle();
    @(negedge clk);
    #1;
    chk("valid_cycles", valid_seen, 32'd3);

    // BEQ at pc 8, taken and not taken.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      load(0, W_ADD);
      load(1, W_ADD);
      load(2, W_BEQ);
      load(3, W_ADD);
      do_start();
      idle();
      idle();
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (k == 0), 1'b0, 0, 32'd0);
      idle();
      @(negedge clk);
      chk(k == 0 ? "beq_taken_pc" : "beq_not_taken_pc", bus.pc, k == 0 ? 32'd4 : 32'd12);
    end

    // Jump wins over a simultaneous taken branch.
    do_reset();
    load(0, W_J);
    do_start();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'd0);
    idle();
    @(negedge clk);
    chk("jump_pc", bus.pc, 32'h14);

    // Stall while HALT_WORD is fetched: no halt until the stall drops.
    do_reset();
    load(0, W_ADD);
    load(1, HALT_WORD);
    do_start();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'd0);
      @(negedge clk);
      chk("stall_pc", bus.pc, 32'd4);
      chk("stall_not_halted", {31'd0, bus.halted}, 32'd0);
    end
    idle();
    idle();
    @(negedge clk);
    chk("halt_after_stall", {31'd0, bus.halted}, 32'd1);

    // Run off the end of memory; a write attempted mid-run must be ignored.
    do_reset();
    for (int i = 0; i < 64; i++) load(i, W_ADD);
    do_start();
    for (int k = 0; k < 70; k++) begin
      if (k == 3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 40, HALT_WORD);
      else idle();
      if (k == 64) begin
        @(negedge clk);
        chk("oor_pc", bus.pc, 32'd256);
        chk("oor_instr", bus.instr, 32'd0);
        chk("oor_valid", {31'd0, bus.instr_valid}, 32'd0);
      end
    end
    @(negedge clk);
    chk("oor_halted", {31'd0, bus.halted}, 32'd1);

    // Reset in the middle of a run.
    do_start();
    repeat (5) idle();
    do_reset();
    idle();
    @(negedge clk);
    chk("midrun_reset_pc", bus.pc, 32'd0);
    chk("midrun_reset_valid", {31'd0, bus.instr_valid}, 32'd0);

    // Randomised programs and control inputs.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < 64; i++) load(i, rand_word());
      do_start();
      for (int c = 0; c < 300; c++) begin
        cycle(($urandom % 64) != 0, ($urandom % 16) == 0, ($urandom % 4) == 0,
              ($urandom % 4) == 0, ($urandom % 8) == 0, $urandom % 2,
              ($urandom % 8) == 0, $urandom_range(0, 63), rand_word());
      end
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle MIPS datapath. It holds the program counter and the instruction memory, and splits the fetched word into fields for the main control decoder and the register bank. It resolves the next PC from the control unit's `branch`/`jump` outputs and the ALU `Zero` flag. A small run-control FSM provides start, stall and halt, so a bench or host can load a program and then run it.

## Interface
Parameters:
- `IMEM_DEPTH`, 64: instruction memory size in 32-bit words; must be a power of two.
- `HALT_WORD`, 32'hFC00_0000: instruction word (opcode 6'b111111) that stops execution.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: leave IDLE/HALT and begin execution at PC 0.
- `stall` in 1: hold PC and state this cycle.
- `branch` in 1: from main control.
- `jump` in 1: from main control.
- `Zero` in 1: from ALU.
- `imem_we` in 1: program-load write enable.
- `imem_waddr` in log2(IMEM_DEPTH): word address to write.
- `imem_wdata` in 32: word to write.
- `instr` out 32: fetched word.
- `opcode` out 6: `instr[31:26]`.
- `rs` out 5: `instr[25:21]`.
- `rt` out 5: `instr[20:16]`.
- `rd` out 5: `instr[15:11]`.
- `func` out 6: `instr[5:0]`.
- `imm16` out 16: `instr[15:0]`.
- `pc` out 32: current PC (byte address).
- `pc_plus4` out 32: `pc + 4`.
- `instr_valid` out 1: instruction is live and the datapath may commit it.
- `halted` out 1: FSM is in HALT.

## Operation
- FSM states: IDLE, RUN, HALT.
  - Reset forces IDLE and `pc`=0.
  - Memory contents are not cleared by reset.
- IDLE:
  - `start`=1 goes to RUN; `pc` stays 0.
  - `imem_we` writes are accepted.
- RUN, `stall`=0:
  - `pc` ← next_pc each cycle.
  - If `instr`==HALT_WORD, go to HALT and leave `pc` unchanged.
  - If the PC is out of range (`pc[31:log2(IMEM_DEPTH)+2]`≠0), go to HALT and leave `pc` unchanged.
- RUN, `stall`=1:
  - `pc` and state hold.
  - Halt detection is suppressed.
- HALT:
  - `start`=1 goes to RUN with `pc`←0.
  - `imem_we` writes are accepted.
- `imem_we` is ignored in RUN.
- next_pc priority:
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - else `branch & Zero`: `pc_plus4 + ({{14{imm16[15]}}, imm16, 2'b00})`.
  - else `pc_plus4`.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32; overflow wraps silently.
  - `pc[1:0]` is always 0 by construction.
- `instr` is a combinational read of `mem[pc[log2(IMEM_DEPTH)+1:2]]`. It reads 32'h0 when out of range or when not in RUN.
- `instr_valid` = RUN & !stall & !out_of_range & (instr≠HALT_WORD).
- Reset values: `pc`=0, `instr_valid`=0, `halted`=0, `instr`=0 and all field outputs 0.

## Timing
- Fetch-to-field latency is 0 cycles: fields change combinationally with `pc`.
- The PC update takes effect at the rising edge following the control/`Zero` evaluation.
- Branch/jump penalty is 0: the target instruction is presented in the next cycle.
- A memory write at edge N is visible to a fetch at cycle N+1.
- `imem_we` and `start` in the same IDLE cycle: the write completes, RUN begins, and the first fetch sees the new word.
- `start` in RUN has no effect.
- `rst_n` low during RUN returns to IDLE at that edge; any in-flight instruction is dropped.
- `stall` together with `jump`/`branch`: the redirect is lost unless the condition persists until the cycle with `stall`=0. Upstream must hold `stall` steady.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (R-type 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, J 6'b000010, HALT 6'b111111);
  - the FSM state typedef;
  - `HALT_WORD`.
- Natural sub-module: `next_pc`, a combinational block taking pc_plus4, instr, branch, jump and Zero and producing next_pc.
- Memory and FSM stay in this module.

## Test plan
- Reset, load words 0..3 = ADD, SUB, LW, HALT_WORD, then pulse `start`.
  - `pc` steps 0→4→8→12.
  - `halted`=1 on the cycle after `pc`=12.
  - `instr_valid` is 1 for exactly 3 cycles.
- BEQ at pc 8 with `imm16`=16'hFFFE, `branch`=1, `Zero`=1: next `pc`=8+4−8=4. The same case with `Zero`=0 gives next `pc`=12.
- J at pc 0 with target field 26'h000005: next `pc`=32'h14. `jump`=1 and `branch`=1 together: the jump target wins.
- Assert `stall` for 3 cycles at `pc`=4 while `instr` is HALT_WORD.
  - `pc` holds at 4 and the FSM stays in RUN.
  - `halted` rises only after `stall` drops.
- Run with IMEM_DEPTH=64 through sequential code to `pc`=256: state goes to HALT, `instr`=0, `instr_valid`=0.
- Drive `imem_we` during RUN: memory is unchanged. Drive `rst_n`=0 mid-run: `pc`=0 and IDLE on the next edge.
